// File: rtl/ber_lane_counter.sv
// Multi-lane bit-error accumulator: compares LANES-wide words against a reference,
// sums mismatches into a saturating error counter and counts compared bits.
module ber_lane_counter #(
  parameter int LANES = 8,
  parameter int CNT_W = 16,
  parameter int BIT_W = 32,
  parameter int WIN_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIN_W-1:0] window_len,
  input  logic [CNT_W-1:0] threshold,
  input  logic             valid,
  input  logic [LANES-1:0] data_rx,
  input  logic [LANES-1:0] data_ref,
  output logic [CNT_W-1:0] error_count,
  output logic [BIT_W-1:0] bit_count,
  output logic             error_flag,
  output logic             threshold_flag,
  output logic             busy,
  output logic             done
);

  localparam int MIS_W  = $clog2(LANES + 1);
  localparam int ESUM_W = ((CNT_W > MIS_W) ? CNT_W : MIS_W) + 1;
  localparam int BSUM_W = ((BIT_W > MIS_W) ? BIT_W : MIS_W) + 1;
  localparam logic [ESUM_W-1:0] ERR_MAX = {{(ESUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};
  localparam logic [BSUM_W-1:0] BIT_MAX = {{(BSUM_W - BIT_W){1'b0}}, {BIT_W{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state;
  logic [WIN_W-1:0]   win_len_q;
  logic [WIN_W-1:0]   sample_cnt;
  logic [WIN_W-1:0]   sample_inc;
  logic               window_hit;
  logic               s1_valid;
  logic [MIS_W-1:0]   s1_mis;
  logic [MIS_W-1:0]   mismatches;
  logic [ESUM_W-1:0]  err_sum;
  logic [BSUM_W-1:0]  bit_sum;
  logic [CNT_W-1:0]   err_next;
  logic [BIT_W-1:0]   bit_next;

  always_comb begin
    mismatches = '0;
    for (int i = 0; i < LANES; i++) begin
      mismatches = mismatches + MIS_W'(data_rx[i] ^ data_ref[i]);
    end
  end

  // Sums are one bit wider than the counters so overflow is visible before clamping.
  assign err_sum = ESUM_W'(error_count) + ESUM_W'(s1_mis);
  assign bit_sum = BSUM_W'(bit_count) + BSUM_W'(LANES);

  always_comb begin
    err_next = err_sum[CNT_W-1:0];
    bit_next = bit_sum[BIT_W-1:0];
    if (err_sum > ERR_MAX) err_next = '1;
    if (bit_sum > BIT_MAX) bit_next = '1;
  end

  // Sample counter saturates so a very long continuous run only ends on stop.
  assign sample_inc = (sample_cnt == '1) ? sample_cnt : sample_cnt + WIN_W'(1);
  assign window_hit = (win_len_q != '0) && (sample_inc == win_len_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      win_len_q      <= '0;
      sample_cnt     <= '0;
      s1_valid       <= 1'b0;
      s1_mis         <= '0;
      error_count    <= '0;
      bit_count      <= '0;
      error_flag     <= 1'b0;
      threshold_flag <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      if (s1_valid) begin
        error_count <= err_next;
        bit_count   <= bit_next;
        if (err_next == '1) error_flag <= 1'b1;
        if ((threshold != '0) && (err_next >= threshold)) threshold_flag <= 1'b1;
      end
      s1_valid <= 1'b0;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_RUN;
            win_len_q      <= window_len;
            sample_cnt     <= '0;
            error_count    <= '0;
            bit_count      <= '0;
            error_flag     <= 1'b0;
            threshold_flag <= 1'b0;
            busy           <= 1'b1;
            done           <= 1'b0;
          end
        end
        S_RUN: begin
          if (valid) begin
            s1_valid   <= 1'b1;
            s1_mis     <= mismatches;
            sample_cnt <= sample_inc;
          end
          if (stop || (valid && window_hit)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ber_lane_counter.sv
// Self-checking bench for ber_lane_counter: a 16-bit and a 4-bit counter instance
// share stimulus and are compared every cycle against an edge-level reference model.
module tb_ber_lane_counter;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_DONE  = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic        valid;
  logic [15:0] window_len;
  logic [15:0] threshold;
  logic [7:0]  data_rx;
  logic [7:0]  data_ref;

  logic [15:0] error_count;
  logic [31:0] bit_count;
  logic        error_flag, threshold_flag, busy, done;
  logic [3:0]  sat_error_count;
  logic [31:0] sat_bit_count;
  logic        sat_error_flag, sat_threshold_flag, sat_busy, sat_done;

  int checks = 0;
  int errors = 0;

  int     m_state, m_win, m_samples, m_err, m_sat_err, p_mis;
  longint m_bits;
  bit     m_ef, m_sat_ef, m_tf, m_sat_tf, p_valid;

  ber_lane_counter #(.LANES(8), .CNT_W(16), .BIT_W(32), .WIN_W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .window_len(window_len), .threshold(threshold), .valid(valid),
    .data_rx(data_rx), .data_ref(data_ref),
    .error_count(error_count), .bit_count(bit_count), .error_flag(error_flag),
    .threshold_flag(threshold_flag), .busy(busy), .done(done)
  );

  ber_lane_counter #(.LANES(8), .CNT_W(4), .BIT_W(32), .WIN_W(16)) dut_sat (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .window_len(window_len), .threshold(threshold[3:0]), .valid(valid),
    .data_rx(data_rx), .data_ref(data_ref),
    .error_count(sat_error_count), .bit_count(sat_bit_count), .error_flag(sat_error_flag),
    .threshold_flag(sat_threshold_flag), .busy(sat_busy), .done(sat_done)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_state = M_IDLE; m_win = 0; m_samples = 0; m_err = 0; m_sat_err = 0; m_bits = 0;
    m_ef = 0; m_sat_ef = 0; m_tf = 0; m_sat_tf = 0; p_valid = 0; p_mis = 0;
  endtask

  // One clock edge of the reference: results from the previous edge become visible now.
  task automatic modelEdge(input bit st, input bit sp, input bit v, input logic [7:0] rx, input logic [7:0] rf);
    int  thr;
    int  thr4;
    bit  clr;
    thr  = int'(threshold);
    thr4 = int'(threshold[3:0]);
    clr  = ((m_state == M_IDLE) || (m_state == M_DONE)) && st;
    if (clr) begin
      m_err = 0; m_sat_err = 0; m_bits = 0; m_ef = 0; m_sat_ef = 0; m_tf = 0; m_sat_tf = 0;
    end else if (p_valid) begin
      m_err     = (m_err + p_mis > 65535) ? 65535 : m_err + p_mis;
      m_sat_err = (m_sat_err + p_mis > 15) ? 15 : m_sat_err + p_mis;
      m_bits    = (m_bits + 8 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_bits + 8;
      if (m_err == 65535) m_ef = 1;
      if (m_sat_err == 15) m_sat_ef = 1;
      if (thr != 0 && m_err >= thr) m_tf = 1;
      if (thr4 != 0 && m_sat_err >= thr4) m_sat_tf = 1;
    end
    p_valid = 0;
    case (m_state)
      M_IDLE, M_DONE: if (clr) begin
        m_state = M_RUN; m_win = int'(window_len); m_samples = 0;
      end
      M_RUN: begin
        if (v) begin
          p_valid = 1;
          p_mis   = $countones(rx ^ rf);
          if (m_samples < 65535) m_samples++;
        end
        if (sp || (v && m_win != 0 && m_samples == m_win)) m_state = M_DRAIN;
      end
      default: m_state = M_DONE;
    endcase
  endtask

  task automatic checkAll();
    checkOutput("error_count", error_count, m_err);
    checkOutput("bit_count", bit_count, m_bits);
    checkOutput("error_flag", error_flag, m_ef);
    checkOutput("threshold_flag", threshold_flag, m_tf);
    checkOutput("busy", busy, (m_state == M_RUN) || (m_state == M_DRAIN));
    checkOutput("done", done, m_state == M_DONE);
    checkOutput("sat_error_count", sat_error_count, m_sat_err);
    checkOutput("sat_bit_count", sat_bit_count, m_bits);
    checkOutput("sat_error_flag", sat_error_flag, m_sat_ef);
    checkOutput("sat_threshold_flag", sat_threshold_flag, m_sat_tf);
    checkOutput("sat_busy", sat_busy, (m_state == M_RUN) || (m_state == M_DRAIN));
  endtask

  task automatic applyStimulus(input bit st, input bit sp, input bit v, input logic [7:0] rx, input logic [7:0] rf);
    start = st; stop = sp; valid = v; data_rx = rx; data_ref = rf;
    @(posedge clock);
    modelEdge(st, sp, v, rx, rf);
    #1;
    checkAll();
    start = 1'b0; stop = 1'b0; valid = 1'b0;
  endtask

  function automatic logic [7:0] flipBits(input logic [7:0] rx, input int n);
    logic [7:0] m;
    m = '0;
    while ($countones(m) < n) m[$urandom_range(7, 0)] = 1'b1;
    return rx ^ m;
  endfunction

  task automatic sendWord(input int nmis, input bit sp);
    logic [7:0] rx;
    rx = 8'($urandom);
    applyStimulus(1'b0, sp, 1'b1, rx, flipBits(rx, nmis));
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
  endtask

  // Data on the start cycle is deliberately mismatching; it must not be counted.
  task automatic startRun(input int win, input int thr);
    logic [7:0] rx;
    window_len = 16'(win);
    threshold  = 16'(thr);
    rx = 8'($urandom);
    applyStimulus(1'b1, 1'b0, 1'b1, rx, ~rx);
  endtask

  initial begin
    bit flags[100];
    reset = 1'b1; start = 0; stop = 0; valid = 0;
    window_len = '0; threshold = '0; data_rx = '0; data_ref = '0;
    modelReset();
    repeat (2) @(posedge clock);
    #1;
    checkAll();
    reset = 1'b0;

    $display("[TB] window run, mismatches 1,0,8,3");
    startRun(4, 0);
    sendWord(1, 0); sendWord(0, 0); sendWord(8, 0); sendWord(3, 0);
    checkOutput("win_busy_in_drain", busy, 1);
    checkOutput("win_not_done_yet", done, 0);
    idleCycle();
    checkOutput("win_done", done, 1);
    checkOutput("win_busy_low", busy, 0);
    checkOutput("win_error_count", error_count, 12);
    checkOutput("win_bit_count", bit_count, 32);
    checkOutput("win_error_flag", error_flag, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h0F, 8'hF0);
    checkOutput("win_done_holds", error_count, 12);

    $display("[TB] continuous run, 100 samples with 50 single-bit errors");
    for (int i = 0; i < 100; i++) flags[i] = (i < 50);
    for (int i = 99; i > 0; i--) begin
      int j;
      bit t;
      j = $urandom_range(i, 0);
      t = flags[i]; flags[i] = flags[j]; flags[j] = t;
    end
    startRun(0, 0);
    for (int i = 0; i < 100; i++) sendWord(flags[i] ? 1 : 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    idleCycle();
    checkOutput("cont_error_count", error_count, 50);
    checkOutput("cont_bit_count", bit_count, 800);
    checkOutput("cont_done", done, 1);
    checkOutput("cont_sat_count", sat_error_count, 15);

    $display("[TB] saturation on the 4-bit instance");
    startRun(3, 0);
    sendWord(8, 0); sendWord(8, 0); sendWord(8, 0);
    idleCycle();
    checkOutput("sat_count_15", sat_error_count, 15);
    checkOutput("sat_flag_set", sat_error_flag, 1);
    checkOutput("sat_wide_24", error_count, 24);
    startRun(0, 0);
    checkOutput("sat_cleared", sat_error_count, 0);
    checkOutput("sat_flag_cleared", sat_error_flag, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    idleCycle();

    $display("[TB] threshold 10 then threshold 0");
    startRun(3, 10);
    sendWord(4, 0); sendWord(4, 0); sendWord(4, 0);
    checkOutput("thr_count_8", error_count, 8);
    checkOutput("thr_flag_low", threshold_flag, 0);
    idleCycle();
    checkOutput("thr_count_12", error_count, 12);
    checkOutput("thr_flag_rise", threshold_flag, 1);
    startRun(3, 0);
    sendWord(4, 0); sendWord(4, 0); sendWord(4, 0);
    idleCycle();
    checkOutput("thr_disabled", threshold_flag, 0);

    $display("[TB] stop with valid, start ignored in RUN, gaps");
    startRun(0, 0);
    sendWord(1, 0);
    idleCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hA5, 8'hA4);
    checkOutput("start_in_run_ignored", error_count, 1);
    idleCycle();
    sendWord(3, 0);
    sendWord(2, 1);
    idleCycle();
    checkOutput("stopv_error_count", error_count, 7);
    checkOutput("stopv_bit_count", bit_count, 32);
    checkOutput("stopv_done", done, 1);

    $display("[TB] randomized runs");
    for (int r = 0; r < 6; r++) begin
      int n;
      bit cont;
      cont = (r % 3 == 2);
      startRun(cont ? 0 : $urandom_range(12, 3), $urandom_range(30, 0));
      n = 0;
      while (m_state == M_RUN && n < 60) begin
        logic [7:0] rx;
        rx = 8'($urandom);
        applyStimulus(1'b0, cont && ($urandom_range(14, 0) == 0), $urandom_range(1, 0) == 1,
                      rx, flipBits(rx, $urandom_range(8, 0)));
        n++;
      end
      if (m_state == M_RUN) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      idleCycle();
      idleCycle();
      checkOutput("rand_done", done, 1);
    end

    $display("[TB] asynchronous reset mid-run");
    startRun(0, 0);
    for (int i = 0; i < 7; i++) sendWord(1, 0);
    checkOutput("rst_pre_count", error_count, 6);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_error_count", error_count, 0);
    checkOutput("rst_bit_count", bit_count, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_error_flag", error_flag, 0);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF, 8'h00);
    checkOutput("rst_stays_zero", error_count, 0);
    checkOutput("rst_stays_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ber_lane_counter.md
# ber_lane_counter

Parametrised multi-lane bit-error accumulator for the bit error tester. It compares a LANES-wide received word against the reference pattern every valid cycle and adds the mismatch popcount to a saturating error counter. In parallel it counts the compared bits, so software can form a BER. It sits between the pattern checker and the hex display / host readout, and supports both continuous and fixed-window measurement runs.

## Interface
- LANES, 8, bits compared per valid cycle (1..64)
- CNT_W, 16, error counter width (display uses low 16 bits)
- BIT_W, 32, compared-bit counter width
- WIN_W, 16, width of window length and sample counter
- clock  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-high; returns all state to reset values
- start  in  1  pulse; clears counters and begins a run (honoured in IDLE or DONE only)
- stop  in  1  pulse; ends a continuous run (honoured in RUN only)
- window_len  in  WIN_W  samples per run; 0 = continuous; sampled on the start cycle
- threshold  in  CNT_W  error alarm level; 0 disables the alarm
- valid  in  1  data_rx/data_ref qualify this cycle
- data_rx  in  LANES  received bits
- data_ref  in  LANES  reference pattern bits
- error_count  out  CNT_W  accumulated errors; reset 0
- bit_count  out  BIT_W  accumulated compared bits; reset 0
- error_flag  out  1  sticky, error_count saturated at all-ones; reset 0
- threshold_flag  out  1  sticky, error_count >= threshold (threshold != 0); reset 0
- busy  out  1  high in RUN or DRAIN; reset 0
- done  out  1  high in DONE; counts are final; reset 0

## Operation
- FSM states: IDLE (reset state), RUN, DRAIN, DONE.
- IDLE/DONE + start: clear error_count, bit_count, error_flag, threshold_flag and sample counter; latch window_len; go to RUN.
- RUN: a sample is accepted when valid=1. On acceptance:
  - the mismatch count popcount(data_rx ^ data_ref) is registered into stage 1;
  - the sample counter increments.
- RUN exit: go to DRAIN when stop=1, or when latched window_len != 0 and the sample counter reaches window_len on this acceptance. A sample accepted in the exit cycle is counted.
- DRAIN: lasts exactly one cycle; the stage-1 value is accumulated; no new samples are accepted; then go to DONE.
- DONE holds all counts until the next start or reset. start is ignored in RUN/DRAIN; stop is ignored outside RUN.
- Stage 2 accumulate, for each stage-1 entry marked valid:
  - error_count = min(error_count + mismatches, 2^CNT_W-1), computed at CNT_W+1 bits;
  - bit_count = min(bit_count + LANES, 2^BIT_W-1).
  Both counters saturate and never wrap.
- error_flag sets on the edge at which error_count becomes all-ones.
- threshold_flag sets on the edge at which the new error_count >= threshold, when threshold != 0. It is evaluated against the live threshold input.
- Continuous mode with a saturated sample counter: the sample counter also saturates; the run ends only on stop.
- reset mid-run: all state and outputs return to reset values immediately; the in-flight sample is discarded.

## Timing
- start sampled at edge t0: busy=1 and counters=0 after t0. Data presented in the same cycle as start is not accepted.
- Sample accepted at edge k → stage 1 at k → error_count/bit_count/flags updated at edge k+1. Latency is 2 edges from data presentation to visible count.
- Final sample at edge k → state DRAIN after k → DONE after k+1. done=1 and busy=0 from edge k+1. Counts are final when done=1.
- Full throughput: one LANES-wide sample per cycle, no back-pressure.

## Test plan
- Window, LANES=8, window_len=4, four valid words with 1, 0, 8, 3 mismatching bits → done after 2 edges past the last word; error_count=12, bit_count=32, error_flag=0.
- Continuous, window_len=0, valid in 100 cycles of which 50 have a 1-bit mismatch, then stop → error_count=50, bit_count=800, DONE.
- Saturation, CNT_W=4, all lanes mismatching on 3 samples (8+8+8) → error_count=15, error_flag=1. After start it re-clears to 0 and the flag to 0.
- Threshold=10: mismatches 4, 4, 4 → threshold_flag rises at the edge where error_count goes to 12. With threshold=0 the flag stays 0.
- stop and valid in the same cycle with a 2-bit mismatch → that sample is counted; start during RUN is ignored; valid gaps are not counted in bit_count.
- reset asserted asynchronously mid-RUN with count 7 → all outputs 0 immediately, FSM IDLE, counters remain 0 until the next start.
